e_pwm_gen: RTL and testbench

// - Downstream consumer of e_counter: compares the free-running count (0..max, wraps to 0) against a duty value
//   and drives a registered PWM output, one pulse train per counter period.
// - New duty values arrive over a valid/ready handshake. Each is held in a shadow register and applied only at
//   a period boundary, so the output never glitches mid-period.
// - Also flags each period end for downstream timing logic.

---
 rtl/e_pwm_gen_pkg.sv | 12 +
 rtl/e_duty_shadow.sv | 39 +++
 rtl/e_pwm_gen.sv | 72 +++++++
 tb/tb_e_pwm_gen.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/e_pwm_gen_pkg.sv
// Shared types and defaults for the PWM generator and its duty shadow register.
package e_pwm_gen_pkg;

  localparam int PWM_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } pwm_state_t;

endpackage

// File: rtl/e_duty_shadow.sv
// Duty shadow/active register pair with a one-deep valid/ready handshake.
// A captured value reaches duty_active only at a period boundary.
module e_duty_shadow
  import e_pwm_gen_pkg::*;
#(
  parameter int W = PWM_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         accept,
  input  logic         boundary,
  input  logic [W-1:0] duty,
  output logic [W-1:0] duty_active,
  output logic         ready
);

  logic [W-1:0] duty_shadow;

  // ready low means a value is parked in duty_shadow waiting for the boundary.
  // An accept that lands on a boundary bypasses the wait and stays ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_shadow <= '0;
      duty_active <= '0;
      ready       <= 1'b1;
    end else if (accept) begin
      duty_shadow <= duty;
      if (boundary) begin
        duty_active <= duty;
      end else begin
        ready <= 1'b0;
      end
    end else if (boundary && !ready) begin
      duty_active <= duty_shadow;
      ready       <= 1'b1;
    end
  end

endmodule

// File: rtl/e_pwm_gen.sv
// PWM generator: compares an external free-running count against a shadowed
// duty value, producing a registered pulse train and a period-end strobe.
module e_pwm_gen
  import e_pwm_gen_pkg::*;
#(
  parameter int W = PWM_W
) (
  input  logic         _i_clk,
  input  logic         _i_rst_n,
  input  logic [W-1:0] _i_count,
  input  logic [W-1:0] _i_max,
  input  logic [W-1:0] _i_duty,
  input  logic         _i_duty_valid,
  output logic         _o_duty_ready,
  output logic         _o_pwm,
  output logic         _o_period_end
);

  pwm_state_t   state;
  pwm_state_t   state_next;
  logic         boundary;
  logic         accept;
  logic         pwm_next;
  logic [W-1:0] duty_active;

  // >= rather than == so a max lowered below the current count still closes the period.
  assign boundary = (_i_count >= _i_max);
  assign accept   = _i_duty_valid & _o_duty_ready;

  e_duty_shadow #(.W(W)) u_shadow (
    .clk         (_i_clk),
    .rst_n       (_i_rst_n),
    .accept      (accept),
    .boundary    (boundary),
    .duty        (_i_duty),
    .duty_active (duty_active),
    .ready       (_o_duty_ready)
  );

  always_comb begin
    state_next = state;
    pwm_next   = 1'b0;
    case (state)
      IDLE: begin
        if (accept && !boundary) state_next = PEND;
        else if (boundary)       state_next = RUN;
      end
      RUN: begin
        if (accept && !boundary) state_next = PEND;
      end
      PEND: begin
        if (boundary) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
    // Same-width compare: any duty above max keeps the output high all period.
    if (state != IDLE) pwm_next = (_i_count < duty_active);
  end

  always_ff @(posedge _i_clk or negedge _i_rst_n) begin
    if (!_i_rst_n) begin
      state         <= IDLE;
      _o_pwm        <= 1'b0;
      _o_period_end <= 1'b0;
    end else begin
      state         <= state_next;
      _o_pwm        <= pwm_next;
      _o_period_end <= boundary;
    end
  end

endmodule

// File: tb/tb_e_pwm_gen.sv
// Self-checking bench for e_pwm_gen: directed vector table plus randomized
// stimulus against a transaction-level reference model.
module tb_e_pwm_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] count;
  logic [7:0] max;
  logic [7:0] duty;
  logic       duty_valid;
  logic       duty_ready;
  logic       pwm;
  logic       period_end;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       pwm;
    logic       pe;
    logic       rdy;
  } vec_t;

  vec_t vecs[42];
  int   nvec = 0;

  // Reference model state: active duty, queue of at most one pending value,
  // and whether the output has left its post-reset idle hold.
  logic [7:0] m_active;
  logic [7:0] m_pend_q[$];
  bit         m_started;
  logic       exp_pwm;
  logic       exp_pe;
  logic       exp_ready;

  always #5 clk = ~clk;

  // Stand-in for e_counter: counts 0..max and wraps.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= 8'd0;
    else        count <= (count >= max) ? 8'd0 : count + 8'd1;
  end

  e_pwm_gen #(.W(8)) dut (
    ._i_clk        (clk),
    ._i_rst_n      (rst_n),
    ._i_count      (count),
    ._i_max        (max),
    ._i_duty       (duty),
    ._i_duty_valid (duty_valid),
    ._o_duty_ready (duty_ready),
    ._o_pwm        (pwm),
    ._o_period_end (period_end)
  );

  task automatic modelReset();
    m_active = 8'd0;
    m_pend_q.delete();
    m_started = 1'b0;
    exp_pwm   = 1'b0;
    exp_pe    = 1'b0;
    exp_ready = 1'b1;
  endtask

  // Outputs after the coming edge follow from the values present before it.
  task automatic modelStep(input logic v, input logic [7:0] d);
    bit         bnd;
    bit         acc;
    logic [7:0] tmp;
    bnd     = (count >= max);
    acc     = v && (m_pend_q.size() == 0);
    exp_pwm = m_started && (int'(count) < int'(m_active));
    exp_pe  = bnd;
    if (acc && bnd) begin
      m_active  = d;
      m_started = 1'b1;
    end else if (acc) begin
      m_pend_q.push_back(d);
      m_started = 1'b1;
    end else if (bnd) begin
      if (m_pend_q.size() != 0) begin
        tmp = m_pend_q.pop_front();
        m_active = tmp;
      end
      m_started = 1'b1;
    end
    exp_ready = (m_pend_q.size() == 0);
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d);
    duty_valid = v;
    duty       = d;
    modelStep(v, d);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0b expected %0b (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic addVec(input logic v, input logic [7:0] d, input logic p, input logic e, input logic r);
    vecs[nvec] = '{v: v, d: d, pwm: p, pe: e, rdy: r};
    nvec++;
  endtask

  initial begin
    // max=2 throughout: count before each edge runs 0,1,2,0,...
    addVec(1, 8'd1,   0, 0, 0);  addVec(0, 8'd0, 0, 0, 0);  addVec(0, 8'd0, 0, 1, 1);
    addVec(0, 8'd0,   1, 0, 1);  addVec(0, 8'd0, 0, 0, 1);  addVec(0, 8'd0, 0, 1, 1);
    addVec(0, 8'd0,   1, 0, 1);  addVec(0, 8'd0, 0, 0, 1);  addVec(0, 8'd0, 0, 1, 1);
    addVec(1, 8'd2,   1, 0, 0);  addVec(0, 8'd0, 0, 0, 0);  addVec(0, 8'd0, 0, 1, 1);
    addVec(0, 8'd0,   1, 0, 1);  addVec(0, 8'd0, 1, 0, 1);  addVec(0, 8'd0, 0, 1, 1);
    addVec(1, 8'd1,   1, 0, 0);  addVec(1, 8'd3, 1, 0, 0);  addVec(1, 8'd3, 0, 1, 1);
    addVec(1, 8'd3,   1, 0, 0);  addVec(0, 8'd0, 0, 0, 0);  addVec(0, 8'd0, 0, 1, 1);
    addVec(0, 8'd0,   1, 0, 1);  addVec(0, 8'd0, 1, 0, 1);  addVec(0, 8'd0, 1, 1, 1);
    addVec(0, 8'd0,   1, 0, 1);  addVec(0, 8'd0, 1, 0, 1);  addVec(1, 8'd2, 1, 1, 1);
    addVec(0, 8'd0,   1, 0, 1);  addVec(0, 8'd0, 1, 0, 1);  addVec(0, 8'd0, 0, 1, 1);
    addVec(0, 8'd0,   1, 0, 1);  addVec(0, 8'd0, 1, 0, 1);  addVec(1, 8'd0, 0, 1, 1);
    addVec(0, 8'd0,   0, 0, 1);  addVec(0, 8'd0, 0, 0, 1);  addVec(0, 8'd0, 0, 1, 1);
    addVec(0, 8'd0,   0, 0, 1);  addVec(0, 8'd0, 0, 0, 1);  addVec(1, 8'd255, 0, 1, 1);
    addVec(0, 8'd0,   1, 0, 1);  addVec(0, 8'd0, 1, 0, 1);  addVec(0, 8'd0, 1, 1, 1);

    rst_n      = 1'b0;
    duty_valid = 1'b0;
    duty       = 8'd0;
    max        = 8'd2;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("reset_pwm",   pwm,        1'b0);
    checkOutput("reset_pe",    period_end, 1'b0);
    checkOutput("reset_ready", duty_ready, 1'b1);
    rst_n = 1'b1;

    for (int i = 0; i < nvec; i++) begin
      applyStimulus(vecs[i].v, vecs[i].d);
      checkOutput($sformatf("vec%0d_pwm", i),   pwm,        vecs[i].pwm);
      checkOutput($sformatf("vec%0d_pe", i),    period_end, vecs[i].pe);
      checkOutput($sformatf("vec%0d_ready", i), duty_ready, vecs[i].rdy);
    end

    // Park a value in the shadow, then reset between edges: everything clears at once.
    applyStimulus(1'b1, 8'd1);
    checkOutput("prereset_pwm",   pwm,        exp_pwm);
    checkOutput("prereset_ready", duty_ready, exp_ready);
    duty_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_pwm",   pwm,        1'b0);
    checkOutput("async_pe",    period_end, 1'b0);
    checkOutput("async_ready", duty_ready, 1'b1);
    @(negedge clk);
    modelReset();
    rst_n = 1'b1;

    for (int c = 0; c < 600; c++) begin
      logic       v;
      logic [7:0] d;
      if (c % 40 == 0) max = 8'($urandom_range(0, 4));
      else if ($urandom_range(0, 60) == 0) max = 8'($urandom_range(0, 6));
      v = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
      applyStimulus(v, d);
      checkOutput("rand_pwm",   pwm,        exp_pwm);
      checkOutput("rand_pe",    period_end, exp_pe);
      checkOutput("rand_ready", duty_ready, exp_ready);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
